// File: rtl/led_tube_ctrl.sv
// Digit-register controller feeding the 4-digit seven-segment driver.
// Two requesters share the digit registers through a req/gnt handshake
// with round-robin arbitration. An optional prescaled BCD counter
// increments the digits on each prescaler wrap.
module led_tube_ctrl #(
   parameter int unsigned TICK_DIV = 2000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic       clr,
   input  logic       req0,
   input  logic [1:0] addr0,
   input  logic [3:0] wdata0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [1:0] addr1,
   input  logic [3:0] wdata1,
   output logic       gnt1,
   output logic [3:0] data0,
   output logic [3:0] data1,
   output logic [3:0] data2,
   output logic [3:0] data3,
   output logic       tick
);

   logic [CNT_W-1:0] presc;
   logic [3:0]       dig [4];
   logic             last;

   logic             elig0, elig1;
   logic             win0, win1;
   logic             wrap;
   logic [3:0]       inc [4];

   // A requester granted last cycle sits out this cycle; ties go to the one not served last.
   always_comb begin
      elig0 = req0 & ~gnt0;
      elig1 = req1 & ~gnt1;
      win0  = elig0 & (~elig1 | last);
      win1  = elig1 & (~elig0 | ~last);
      wrap  = mode & (presc == CNT_W'(TICK_DIV - 1));
   end

   // BCD +1 across the four digits; any digit of 9 or above rolls to 0 and carries.
   always_comb begin
      logic carry;
      carry = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         inc[i] = dig[i];
         if (carry) begin
            if (dig[i] >= 4'd9) begin
               inc[i] = '0;
            end else begin
               inc[i] = dig[i] + 4'd1;
               carry  = 1'b0;
            end
         end
      end
   end

   // Digit registers, grants, prescaler and tick: clr beats writes, writes beat increments.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 4; i++) dig[i] <= '0;
         presc <= '0;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         tick  <= 1'b0;
         last  <= 1'b1;
      end else if (clr) begin
         for (int unsigned i = 0; i < 4; i++) dig[i] <= '0;
         presc <= '0;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         tick  <= 1'b0;
      end else begin
         if (mode) begin
            presc <= wrap ? '0 : presc + CNT_W'(1);
         end else begin
            presc <= '0;
         end
         tick <= wrap;
         gnt0 <= win0;
         gnt1 <= win1;
         if (win0) begin
            dig[addr0] <= wdata0;
            last       <= 1'b0;
         end else if (win1) begin
            dig[addr1] <= wdata1;
            last       <= 1'b1;
         end else if (wrap) begin
            for (int unsigned i = 0; i < 4; i++) dig[i] <= inc[i];
         end
      end
   end

   assign data0 = dig[0];
   assign data1 = dig[1];
   assign data2 = dig[2];
   assign data3 = dig[3];

endmodule

// File: tb/tb_led_tube_ctrl.sv
// Directed bench for led_tube_ctrl with a short prescaler period.
module tb_led_tube_ctrl;

   logic       clk;
   logic       rst;
   logic       mode;
   logic       clr;
   logic       req0;
   logic [1:0] addr0;
   logic [3:0] wdata0;
   logic       gnt0;
   logic       req1;
   logic [1:0] addr1;
   logic [3:0] wdata1;
   logic       gnt1;
   logic [3:0] data0, data1, data2, data3;
   logic       tick;

   int errors = 0;
   int checks = 0;

   led_tube_ctrl #(.TICK_DIV(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .mode(mode), .clr(clr),
      .req0(req0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
      .req1(req1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] digits();
      return {data3, data2, data1, data0};
   endfunction

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0; mode = 1'b0; clr = 1'b0;
      req0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; addr1 = '0; wdata1 = '0;
      #2;
      rst = 1'b1;
   endtask

   // single write through requester 0 while nothing else competes
   task automatic write0(input logic [1:0] a, input logic [3:0] v);
      req0 = 1'b1; addr0 = a; wdata0 = v;
      step();
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++;
         $display("FAIL write0_gnt addr=%0d got=%b exp=1", a, gnt0);
      end
      req0 = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0; mode = 1'b0; clr = 1'b0;
      req0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; addr1 = '0; wdata1 = '0;
      #2;
      checks++;
      if ({digits(), gnt0, gnt1, tick} !== 19'd0) begin
         errors++;
         $display("FAIL reset_async got=%h exp=0", {digits(), gnt0, gnt1, tick});
      end
      #1 rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if ({digits(), gnt0, gnt1, tick} !== 19'd0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, {digits(), gnt0, gnt1, tick});
         end
      end
   endtask

   task automatic test_single();
      logic [2:0] exp_g;
      do_reset();
      exp_g = 3'b101;
      req0 = 1'b1; addr0 = 2'd2; wdata0 = 4'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (gnt0 !== exp_g[i] || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt edge=%0d got=%b%b exp=%b0", i + 1, gnt0, gnt1, exp_g[i]);
         end
         checks++;
         if (digits() !== 16'h0700) begin
            errors++;
            $display("FAIL single_data edge=%0d got=%h exp=0700", i + 1, digits());
         end
      end
      req0 = 1'b0;
      step();
      checks++;
      if (gnt0 !== 1'b0) begin
         errors++;
         $display("FAIL single_drop got=%b exp=0", gnt0);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_g0, exp_g1;
      do_reset();
      exp_g0 = 4'b0101;
      exp_g1 = 4'b1010;
      req0 = 1'b1; addr0 = 2'd0; wdata0 = 4'd5;
      req1 = 1'b1; addr1 = 2'd1; wdata1 = 4'd3;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (gnt0 !== exp_g0[i] || gnt1 !== exp_g1[i]) begin
            errors++;
            $display("FAIL arb_gnt edge=%0d got=%b%b exp=%b%b", i + 1, gnt0, gnt1, exp_g0[i], exp_g1[i]);
         end
      end
      checks++;
      if (digits() !== 16'h0035) begin
         errors++;
         $display("FAIL arb_data got=%h exp=0035", digits());
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
   endtask

   task automatic test_wrap9999();
      do_reset();
      for (int i = 0; i < 4; i++) write0(2'(i), 4'd9);
      checks++;
      if (digits() !== 16'h9999) begin
         errors++;
         $display("FAIL preset_9999 got=%h exp=9999", digits());
      end
      mode = 1'b1;
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (tick !== 1'b0) begin
               errors++;
               $display("FAIL wrap_tick_low t=%0d i=%0d got=%b exp=0", t, i, tick);
            end
         end
         step();
         checks++;
         if (tick !== 1'b1 || digits() !== (t == 0 ? 16'h0000 : 16'h0001)) begin
            errors++;
            $display("FAIL wrap_inc t=%0d got tick=%b data=%h exp tick=1 data=%h",
                     t, tick, digits(), (t == 0 ? 16'h0000 : 16'h0001));
         end
      end
   endtask

   task automatic test_over9();
      do_reset();
      write0(2'd0, 4'd14);
      checks++;
      if (digits() !== 16'h000E) begin
         errors++;
         $display("FAIL raw_store got=%h exp=000e", digits());
      end
      mode = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (tick !== 1'b1 || digits() !== 16'h0010) begin
         errors++;
         $display("FAIL over9_inc got tick=%b data=%h exp tick=1 data=0010", tick, digits());
      end
   endtask

   task automatic test_collision();
      do_reset();
      write0(2'd0, 4'd9);
      mode = 1'b1;
      for (int i = 0; i < 3; i++) step();
      req0 = 1'b1; addr0 = 2'd3; wdata0 = 4'd2;
      step();
      checks++;
      if (gnt0 !== 1'b1 || tick !== 1'b1 || digits() !== 16'h2009) begin
         errors++;
         $display("FAIL collide got gnt0=%b tick=%b data=%h exp gnt0=1 tick=1 data=2009",
                  gnt0, tick, digits());
      end
      req0 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (tick !== 1'b1 || digits() !== 16'h2010) begin
         errors++;
         $display("FAIL collide_next got tick=%b data=%h exp tick=1 data=2010", tick, digits());
      end
   endtask

   // continues from test_collision: mode=1, prescaler just wrapped
   task automatic test_clr();
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (tick !== 1'b0 || digits() !== 16'h0000) begin
         errors++;
         $display("FAIL clr got tick=%b data=%h exp tick=0 data=0000", tick, digits());
      end
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (tick !== 1'b0) begin
         errors++;
         $display("FAIL clr_presc_early got=%b exp=0", tick);
      end
      step();
      checks++;
      if (tick !== 1'b1 || digits() !== 16'h0001) begin
         errors++;
         $display("FAIL clr_presc_restart got tick=%b data=%h exp tick=1 data=0001", tick, digits());
      end
      for (int i = 0; i < 3; i++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++;
      if (tick !== 1'b0 || digits() !== 16'h0000) begin
         errors++;
         $display("FAIL clr_on_wrap got tick=%b data=%h exp tick=0 data=0000", tick, digits());
      end
   endtask

   task automatic test_reset_mid();
      req0 = 1'b1; addr0 = 2'd1; wdata0 = 4'd4;
      step();
      req0 = 1'b0;
      checks++;
      if (gnt0 !== 1'b1 || digits() !== 16'h0040) begin
         errors++;
         $display("FAIL mid_write got gnt0=%b data=%h exp gnt0=1 data=0040", gnt0, digits());
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({digits(), gnt0, gnt1, tick} !== 19'd0) begin
         errors++;
         $display("FAIL mid_reset got=%h exp=0", {digits(), gnt0, gnt1, tick});
      end
      #2;
      rst = 1'b1; mode = 1'b0;
      req0 = 1'b1; addr0 = 2'd0; wdata0 = 4'd1;
      req1 = 1'b1; addr1 = 2'd1; wdata1 = 4'd2;
      step();
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || digits() !== 16'h0001) begin
         errors++;
         $display("FAIL post_reset_tie got gnt=%b%b data=%h exp gnt=10 data=0001", gnt0, gnt1, digits());
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap9999();
      test_over9();
      test_collision();
      test_clr();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_tube_ctrl.md
Name: led_tube_ctrl

Overview:
Digit-register controller that sources data0..data3 for the 4-digit seven-segment driver (led_tube). It shares the four digit registers between two write requesters using a req/gnt handshake with round-robin arbitration. It also runs an optional free-running 4-digit BCD counter mode. Its outputs connect directly to the led_tube data inputs.

Parameters:
TICK_DIV, 2000, clock cycles per auto-count tick; legal range >=2. Must exceed one full display scan of led_tube.
CNT_W, 32, width of the tick prescaler counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
mode  input  1  0 = manual (writes only); 1 = auto BCD count plus writes
clr  input  1  synchronous clear of digits and prescaler
req0  input  1  requester 0 write request, level
addr0  input  2  requester 0 digit index (0 = data0 ... 3 = data3)
wdata0  input  4  requester 0 digit value
gnt0  output  1  requester 0 grant, one-cycle pulse
req1  input  1  requester 1 write request, level
addr1  input  2  requester 1 digit index
wdata1  input  4  requester 1 digit value
gnt1  output  1  requester 1 grant, one-cycle pulse
data0  output  4  digit 0 (least significant) to led_tube
data1  output  4  digit 1
data2  output  4  digit 2
data3  output  4  digit 3 (most significant)
tick  output  1  one-cycle pulse at each prescaler wrap

Behaviour:
- Reset (rst=0, asynchronous): data0..3=0, gnt0=gnt1=0, tick=0, prescaler=0, round-robin pointer last=1 (requester 0 wins the first tie). All outputs are registered.
- Per rising edge, priority order: clr > requester write > auto increment.
- clr=1: data0..3<=0, prescaler<=0, gnt0/gnt1<=0, tick<=0. Pointer is unchanged. Pending requests are not served in that cycle.
- Eligibility: reqN=1 and gntN=0. A requester granted at edge k cannot be granted at edge k+1. This gives the requester one cycle to drop or change its request. Max rate per requester is one write every 2 cycles.
- Arbitration: with one eligible requester, it wins. With both eligible, the requester not equal to last wins, then last<=winner.
- Grant: at the winning edge, data[addrN]<=wdataN and gntN<=1. Exactly one write per cycle occurs. gnt0 and gnt1 are never both 1. Write latency is 1 edge, and the new value is visible when gnt is high.
- Requester contract: hold addr and wdata stable while req=1 and gnt=0. Deassert req or present the next write after the gnt cycle.
- Values 10..15 are stored as written, with no saturation.
- Prescaler, in mode=1 only: increments each cycle. At TICK_DIV-1 it wraps to 0 and tick<=1 for one cycle. In mode=0 the prescaler holds at 0 and tick=0. Switching to mode=1 starts counting from 0.
- Auto increment on a tick cycle (the edge where the prescaler wraps):
  - 4-digit BCD +1, with data0 as LSD.
  - A digit >=9 becomes 0 and carries into the next digit.
  - 9999 wraps to 0000. A digit >9 is treated like 9 (becomes 0 and carries).
- Collision: if a write is granted on the same edge as a tick wrap, the write applies and that increment is skipped. tick still pulses.
- clr on a wrap edge: the clr result wins, and tick=0.
- Reset mid-operation: all state returns to reset values immediately, and any in-flight grant is lost.

Test Plan:
- Reset release, mode=0, no requests -> data0..3=0, gnt0=gnt1=0, tick=0 for 20 cycles.
- req0 alone, addr0=2, wdata0=7, held 3 cycles -> gnt0 pulses at edges 1 and 3 (not 2). data2=7 after edge 1, other digits 0.
- req0 and req1 both raised the same cycle (addr0=0/wdata0=5, addr1=1/wdata1=3), held -> gnt0 first, gnt1 next edge, then gnt0 again. data0=5, data1=3, never two grants in one cycle.
- TICK_DIV=4, mode=1, digits preset 9,9,9,9 (data3..data0) via writes -> tick every 4 cycles. First increment gives 0000, next gives 0001.
- TICK_DIV=4, mode=1, digits 0,0,0,9 (data3..data0), write granted on the wrap edge (addr=3, wdata=2) -> data3=2, data0 stays 9 (increment skipped), tick=1. The next tick gives 2,0,1,0.
- During the auto count, clr=1 for one cycle -> all digits 0 and prescaler 0. Then rst=0 pulsed mid-count -> outputs 0 asynchronously, and the next tie goes to requester 0.
